// File: rtl/param_bus_datapath_if.sv
// Control-unit <-> datapath bus bundle for param_bus_datapath.
// master: control unit (drives selects, enables, memory/port data, MD controls).
// slave : datapath (drives bus_out, mar_out, mdr_out, ir_out, md_busy, md_done, dz_err).
interface param_bus_datapath_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16
) ();
    localparam int RW = $clog2(NUM_REGS);

    logic [3:0]          src_sel;
    logic [RW-1:0]       src_reg;
    logic [NUM_REGS-1:0] dst_we;
    logic                pc_in, ir_in, mar_in, hi_in, lo_in, y_in;
    logic                inc_pc;
    logic                mdr_in, mdr_read;
    logic [WIDTH-1:0]    mdata_in, in_port, const_in;
    logic                z_in;
    logic [1:0]          alu_op;
    logic                md_start;
    logic [1:0]          md_mode;
    logic [WIDTH-1:0]    bus_out, mar_out, mdr_out, ir_out;
    logic                md_busy, md_done, dz_err;

    modport master (
        output src_sel, src_reg, dst_we, pc_in, ir_in, mar_in, hi_in, lo_in, y_in,
               inc_pc, mdr_in, mdr_read, mdata_in, in_port, const_in, z_in, alu_op,
               md_start, md_mode,
        input  bus_out, mar_out, mdr_out, ir_out, md_busy, md_done, dz_err
    );

    modport slave (
        input  src_sel, src_reg, dst_we, pc_in, ir_in, mar_in, hi_in, lo_in, y_in,
               inc_pc, mdr_in, mdr_read, mdata_in, in_port, const_in, z_in, alu_op,
               md_start, md_mode,
        output bus_out, mar_out, mdr_out, ir_out, md_busy, md_done, dz_err
    );
endinterface

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/HI/LO/Y, 2W-bit Z,
// one-cycle ALU and an iterative (WIDTH-cycle) multiply/divide unit.
// Ports: clock, clear (async active-high), cu (slave modport of the bus bundle).
module param_bus_datapath #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int R0_ZERO  = 1
) (
    input  logic clock,
    input  logic clear,
    param_bus_datapath_if.slave cu
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    logic [NUM_REGS-1:0][WIDTH-1:0] r_rf;
    logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_hi, r_lo, r_y;
    logic [2*WIDTH-1:0] r_z;
    md_state_t          r_state, w_state_n;
    logic [CW-1:0]      r_cnt;
    // r_acc: product high half / partial remainder; r_mq: multiplier / dividend->quotient
    logic [WIDTH-1:0]   r_acc, r_mq, r_opa;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_dz_err;

    logic [WIDTH-1:0]   w_bus, w_alu, w_alu_hi;
    logic               w_start, w_last, w_sa, w_sb, w_ge;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_acc_n, w_mq_n, w_quo, w_rem;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [2*WIDTH-1:0] w_prod, w_md_res;

    // Bus source mux; encoded select means no contention.
    always_comb begin
        w_bus = '0;
        case (cu.src_sel)
            4'd0: w_bus = (R0_ZERO != 0 && cu.src_reg == '0) ? '0 : r_rf[cu.src_reg];
            4'd1: w_bus = r_hi;
            4'd2: w_bus = r_lo;
            4'd3: w_bus = r_z[2*WIDTH-1:WIDTH];
            4'd4: w_bus = r_z[WIDTH-1:0];
            4'd5: w_bus = r_pc;
            4'd6: w_bus = r_mdr;
            4'd7: w_bus = cu.in_port;
            4'd8: w_bus = cu.const_in;
            default: w_bus = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (cu.alu_op)
            2'b00: w_alu = r_y + w_bus;
            2'b01: w_alu = r_y - w_bus;
            2'b10: w_alu = r_y & w_bus;
            2'b11: w_alu = r_y | w_bus;
            default: w_alu = '0;
        endcase
        w_alu_hi = cu.alu_op[1] ? '0 : {WIDTH{w_alu[WIDTH-1]}};
    end

    // Register loads from the bus.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_rf  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (cu.dst_we[i]) r_rf[i] <= w_bus;
            if (cu.pc_in)       r_pc <= w_bus;
            else if (cu.inc_pc) r_pc <= r_pc + WIDTH'(1);
            if (cu.ir_in)  r_ir  <= w_bus;
            if (cu.mar_in) r_mar <= w_bus;
            if (cu.mdr_in) r_mdr <= cu.mdr_read ? cu.mdata_in : w_bus;
            if (cu.hi_in)  r_hi  <= w_bus;
            if (cu.lo_in)  r_lo  <= w_bus;
            if (cu.y_in)   r_y   <= w_bus;
        end
    end

    // MD sequencer: the done state blocks a back-to-back start for one cycle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (cu.md_start) w_state_n = S_BUSY;
            S_BUSY:  if (w_last)      w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    assign w_start = (r_state == S_IDLE) && cu.md_start;
    assign w_last  = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH - 1));

    // Operand magnitudes; A is Y, B is the bus.
    assign w_sa    = !cu.md_mode[0] && r_y[WIDTH-1];
    assign w_sb    = !cu.md_mode[0] && w_bus[WIDTH-1];
    assign w_mag_a = w_sa ? -r_y : r_y;
    assign w_mag_b = w_sb ? -w_bus : w_bus;

    // One radix-2 step. Divide: borrow out of the (W+1)-bit subtract means "no fit".
    assign w_sum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opa} : '0);
    assign w_diff = {r_acc, r_mq[WIDTH-1]} - {1'b0, r_opa};
    assign w_ge   = ~w_diff[WIDTH];

    always_comb begin
        if (r_is_div) begin
            w_acc_n = w_ge ? w_diff[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
            w_mq_n  = {r_mq[WIDTH-2:0], w_ge};
        end else begin
            w_acc_n = w_sum[WIDTH:1];
            w_mq_n  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
        w_prod = {w_acc_n, w_mq_n};
        // Divide by zero forces an all-ones quotient regardless of sign;
        // the remainder magnitude is already |dividend| and regains its sign.
        w_quo  = r_dz ? '1 : (r_neg_q ? -w_mq_n : w_mq_n);
        w_rem  = r_neg_r ? -w_acc_n : w_acc_n;
        w_md_res = r_is_div ? {w_rem, w_quo} : (r_neg_q ? -w_prod : w_prod);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_z      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_opa    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_dz_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mq     <= cu.md_mode[1] ? w_mag_a : w_mag_b;
                r_opa    <= cu.md_mode[1] ? w_mag_b : w_mag_a;
                r_is_div <= cu.md_mode[1];
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_dz     <= cu.md_mode[1] && (w_bus == '0);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= w_acc_n;
                r_mq  <= w_mq_n;
            end
            if (w_last) begin
                r_z <= w_md_res;
                if (r_dz) r_dz_err <= 1'b1;
            end else if (cu.z_in && r_state != S_BUSY) begin
                r_z <= {w_alu_hi, w_alu};
            end
        end
    end

    assign cu.bus_out = w_bus;
    assign cu.mar_out = r_mar;
    assign cu.mdr_out = r_mdr;
    assign cu.ir_out  = r_ir;
    assign cu.md_busy = (r_state == S_BUSY);
    assign cu.md_done = (r_state == S_DONE);
    assign cu.dz_err  = r_dz_err;
endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Next-generation single-bus CPU datapath core, parametrised in word width and register count.
- Contains the general register file, PC, IR, MAR, MDR, HI, LO, Y and a 2W-bit Z.
- One encoded-source internal bus, so bus contention cannot occur.
- Adds a single-cycle ALU and an iterative multi-cycle multiply/divide unit with start/busy/done handshake. Z is the only result sink for both.
- Driven by the control unit; memory interface via MAR/MDR.

Parameters:
- WIDTH, 32, datapath word width in bits (>=8).
- NUM_REGS, 16, number of general registers (power of 2, >=2).
- R0_ZERO, 1, when 1 R0 reads as 0 on the bus (writes still stored).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- src_sel  in  4  bus source: 0=Rn (src_reg) 1=HI 2=LO 3=ZHI 4=ZLO 5=PC 6=MDR 7=IN_PORT 8=CONST; others drive 0
- src_reg  in  log2(NUM_REGS)  register index when src_sel=0
- dst_we  in  NUM_REGS  per-register write enables, loaded from bus
- pc_in, ir_in, mar_in, hi_in, lo_in, y_in  in  1  load respective register from bus
- inc_pc  in  1  PC <= PC+1
- mdr_in  in  1  load MDR
- mdr_read  in  1  MDR source select: 1=mdata_in, 0=bus
- mdata_in  in  WIDTH  memory read data
- in_port  in  WIDTH  input port data
- const_in  in  WIDTH  sign-extended immediate from IR decode
- z_in  in  1  capture ALU result into Z
- alu_op  in  2  00 ADD, 01 SUB (Y-bus), 10 AND, 11 OR
- md_start  in  1  start multiply/divide
- md_mode  in  2  00 MUL, 01 MULU, 10 DIV, 11 DIVU
- bus_out  out  WIDTH  current bus value
- mar_out  out  WIDTH  MAR
- mdr_out  out  WIDTH  MDR (memory write data)
- ir_out  out  WIDTH  IR
- md_busy  out  1  iterative unit active
- md_done  out  1  one-cycle pulse, result in Z
- dz_err  out  1  sticky divide-by-zero flag

Behaviour:
- Reset: all registers (Rn, PC, IR, MAR, MDR, HI, LO, Y, Z), internal iteration state, md_busy, md_done and dz_err go to 0 asynchronously. Assertion mid-operation aborts the operation with no Z update.
- Bus: combinational mux on src_sel. src_sel 9-15 gives 0. src_sel=0 with src_reg=0 and R0_ZERO=1 gives 0.
- Loads: every enabled register captures the bus on the rising edge. Several destinations in one cycle are allowed.
- PC: pc_in has priority over inc_pc. Increment wraps modulo 2^WIDTH.
- MDR: mdr_in && mdr_read loads mdata_in; mdr_in && !mdr_read loads the bus.
- ALU: Z <= {WIDTH'(sign-extension of result high), result}.
  - ZHI = sign fill for ADD/SUB, 0 for AND/OR.
  - ADD/SUB wrap modulo 2^WIDTH. Latency 1 clock.
  - z_in is ignored while md_busy=1.
- Multiply/divide:
  - Start: md_start accepted only when md_busy=0 and md_done=0. The unit samples Y (operand A) and the bus (operand B) at the accepting edge.
  - After acceptance md_busy=1 for exactly WIDTH cycles. The unit uses radix-2 shift-add / restoring division on magnitudes.
  - At edge k+WIDTH (k = accepting edge): Z is written, md_busy=0 and md_done=1 for one cycle.
  - MUL/MULU: Z = full 2W-bit product (ZHI:ZLO). Signed results are two's complement.
  - DIV/DIVU: ZLO = quotient, ZHI = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
  - Divide by zero: quotient = all ones, remainder = dividend, dz_err set. dz_err stays set until clear.
  - md_start while busy or on the done cycle is ignored and not queued.
  - Y may be reloaded while busy with no effect on the running operation.

Test Plan:
- Reset: clear=1 mid-operation -> all outputs 0 asynchronously; md_busy drops immediately; Z stays 0.
- Move/R0: load R3=0x0000_00A5 via CONST; move R3->R7; src R0 after R0 write of 0x55 -> bus 0; src R7 -> bus 0xA5.
- ALU: Y=5, bus=9, SUB, z_in -> after 1 clock ZLO=0xFFFF_FFFC, ZHI=0xFFFF_FFFF. AND of 0xF0F0 and 0x0FF0 -> ZLO=0x00F0, ZHI=0.
- MUL signed: Y=-3, bus=7, md_start -> md_busy for 32 cycles; done at edge k+32; Z = 0xFFFF_FFFF_FFFF_FFEB. z_in during busy leaves Z unchanged.
- DIVU/DIV: 100/7 -> ZLO=14, ZHI=2. DIV -100/7 -> ZLO=-14, ZHI=-2. Back-to-back md_start on the done cycle is ignored.
- Divide by zero: DIVU 0x1234/0 -> ZLO=0xFFFF_FFFF, ZHI=0x1234, dz_err=1 persisting after a later valid op. PC=0xFFFF_FFFF with inc_pc -> 0; pc_in together with inc_pc loads the bus value.
